// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// One request in flight; addr stays stable while req is high and ack has not arrived.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: PC generation, single-outstanding imem fetch, and a
// small {pc,inst} buffer ahead of IF/ID with branch redirect and stale-fetch squashing.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  imem,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Bit 0 of the encoding is imem.req, so the request comes straight off a flop.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DROP = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [31:0]      pc;
  logic [31:0]      pc_nxt;
  logic [31:0]      tgt;
  logic [31:0]      tgt_nxt;
  logic [31:0]      target;

  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [31:0]      fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;

  logic             ack;
  logic             pop;
  logic             push;
  logic             room;

  assign ack    = imem.ack;
  assign target = branch_addr_i & ~32'h3;

  // A redirect flushes the buffer, so it suppresses both the pop and any push.
  assign pop         = (count != '0) && !stall_i && !branch_i;
  assign push        = (state == S_REQ) && ack && !branch_i;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign room        = count_after < CNT_W'(FIFO_DEPTH);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (branch_i || room) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (branch_i)  state_nxt = ack ? S_REQ : S_DROP;
        else if (ack)  state_nxt = room ? S_REQ : S_IDLE;
      end
      S_DROP: begin
        if (ack) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request flag from the state flop, address from pc
  always_comb begin
    imem.req  = state[0];
    imem.addr = pc;
  end

  // While a squashed request is pending, pc keeps the stale address on the bus
  // and the redirect target waits in tgt until the ack arrives.
  always_comb begin
    pc_nxt  = pc;
    tgt_nxt = tgt;
    unique case (state)
      S_IDLE: begin
        if (branch_i) pc_nxt = target;
      end
      S_REQ: begin
        if (branch_i) begin
          if (ack) pc_nxt  = target;
          else     tgt_nxt = target;
        end else if (ack) begin
          pc_nxt = pc + 32'd4;
        end
      end
      S_DROP: begin
        if (branch_i) begin
          if (ack) pc_nxt  = target;
          else     tgt_nxt = target;
        end else if (ack) begin
          pc_nxt = tgt;
        end
      end
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      pc <= pc_nxt;
      if (branch_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        count <= count_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    tgt <= tgt_nxt;
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= imem.rdata;
    end
  end

  // An empty buffer presents an all-zero instruction slot.
  always_comb begin
    if_valid = (count != '0);
    if_pc    = 32'h0;
    if_inst  = 32'h0;
    if (if_valid) begin
      if_pc   = fifo_pc[rd_ptr];
      if_inst = fifo_inst[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: transaction-level model compared every cycle, plus directed
// scenarios with literal expectations (stream, stall, redirect, reset, PC wrap).
module tb_if_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] baddr = 32'h0;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;
  logic [31:0] if_pc2, if_inst2;
  logic        if_valid2;

  if_fetch_if bus ();
  if_fetch_if bus2 ();

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem(bus), .stall_i(stall), .branch_i(branch),
    .branch_addr_i(baddr), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .imem(bus2), .stall_i(1'b0), .branch_i(1'b0),
    .branch_addr_i(32'h0), .if_pc(if_pc2), .if_inst(if_inst2), .if_valid(if_valid2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: queue of delivered {pc,inst}, one outstanding request
  // (address, squashed flag) and the address the next request will use.
  logic [63:0] mq[$];
  bit          m_out = 1'b0;
  bit          m_sq = 1'b0;
  bit          m_acked;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_next = 32'h0;
  bit          mdl_on = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_out  = 1'b0;
      m_sq   = 1'b0;
      m_next = 32'h0;
    end else begin
      m_acked = m_out && bus.ack;
      if (branch) begin
        mq.delete();
        m_next = baddr & ~32'h3;
      end else begin
        if (mq.size() != 0 && !stall) void'(mq.pop_front());
        if (m_acked && !m_sq) begin
          mq.push_back({m_addr, bus.rdata});
          m_next = m_addr + 32'd4;
        end
      end
      if (m_out && !m_acked) begin
        m_sq = m_sq || branch;
      end else begin
        m_sq  = 1'b0;
        m_out = (mq.size() < DEPTH);
        if (m_out) m_addr = m_next;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("mdl_valid", 32'(if_valid), 32'(mq.size() != 0));
      check("mdl_pc", if_pc, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      check("mdl_inst", if_inst, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
      check("mdl_req", 32'(bus.req), 32'(m_out));
      if (m_out) check("mdl_addr", bus.addr, m_addr);
    end
  end

  // In-order consumption tracker for the streaming and stall scenarios.
  bit          track_en = 1'b0;
  logic [31:0] exp_pc = 32'h0;

  always @(negedge clk) begin
    if (track_en && rst && if_valid && !stall && !branch) begin
      check("seq_pc", if_pc, exp_pc);
      check("seq_inst", if_inst, exp_pc ^ XORK);
      exp_pc = exp_pc + 32'd4;
    end
  end

  // Wrap-around capture from the second instance.
  logic [31:0] q2[$];
  always @(negedge clk) begin
    if (rst && if_valid2 && q2.size() < 3) q2.push_back(if_pc2);
  end

  bit ack_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ack    = ack_en && bus.req;
    bus.rdata  = bus.addr ^ XORK;
    bus2.ack   = bus2.req;
    bus2.rdata = bus2.addr ^ XORK;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] mark;
    bus.ack = 1'b0;   bus.rdata = 32'h0;
    bus2.ack = 1'b0;  bus2.rdata = 32'h0;

    // Reset
    tick();
    mdl_on = 1'b1;
    tick();
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);

    // Streaming fetch, ack every cycle
    rst = 1'b1; ack_en = 1'b1; track_en = 1'b1; exp_pc = 32'h0;
    tick();
    check("t1_first_req", 32'(bus.req), 32'h1);
    check("t1_first_addr", bus.addr, 32'h0);
    repeat (20) tick();
    check("t1_progress", 32'(exp_pc > 32'd40), 32'h1);

    // Wrap-around instance
    check("t6_count", q2.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      v = (q2.size() > i) ? q2[i] : 32'hDEAD_BEEF;
      case (i)
        0: check("t6_pc0", v, 32'hFFFF_FFF8);
        1: check("t6_pc1", v, 32'hFFFF_FFFC);
        default: check("t6_pc2", v, 32'h0000_0000);
      endcase
    end

    // Stall: buffer fills, request drops, head held
    stall = 1'b1;
    repeat (6) tick();
    check("t2_req_off", 32'(bus.req), 32'h0);
    check("t2_valid", 32'(if_valid), 32'h1);
    check("t2_head_pc", if_pc, exp_pc);
    check("t2_head_inst", if_inst, exp_pc ^ XORK);
    mark = exp_pc;
    stall = 1'b0;
    repeat (20) tick();
    check("t2_resume", 32'(exp_pc > mark + 32'd40), 32'h1);
    track_en = 1'b0;

    // Redirect while a request is pending, ack three cycles later
    ack_en = 1'b0;
    tick();
    for (int i = 0; i < 10 && !bus.req; i++) tick();
    check("t3_req_pending", 32'(bus.req), 32'h1);
    branch = 1'b1; baddr = 32'h0000_0103;
    tick();
    branch = 1'b0;
    check("t3_flushed", 32'(if_valid), 32'h0);
    check("t3_req_held", 32'(bus.req), 32'h1);
    tick();
    tick();
    bus.ack = 1'b1;
    ack_en = 1'b1;
    tick();
    check("t3_new_addr", bus.addr, 32'h0000_0100);
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    check("t3_pc", if_pc, 32'h0000_0100);
    check("t3_inst", if_inst, 32'hA5A5_0100);

    // Redirect coinciding with ack and stall
    for (int i = 0; i < 10 && !(bus.req && bus.ack); i++) tick();
    stall = 1'b1; branch = 1'b1; baddr = 32'h0000_0200;
    tick();
    branch = 1'b0;
    check("t4_valid_off", 32'(if_valid), 32'h0);
    check("t4_req", 32'(bus.req), 32'h1);
    check("t4_addr", bus.addr, 32'h0000_0200);
    tick();
    check("t4_pc", if_pc, 32'h0000_0200);
    check("t4_inst", if_inst, 32'hA5A5_0200);
    stall = 1'b0;
    repeat (4) tick();

    // Reset arriving together with the ack of a pending request
    ack_en = 1'b0;
    tick();
    for (int i = 0; i < 10 && !bus.req; i++) tick();
    rst = 1'b0;
    bus.ack = 1'b1;
    tick();
    check("t5_req", 32'(bus.req), 32'h0);
    check("t5_valid", 32'(if_valid), 32'h0);
    check("t5_pc", if_pc, 32'h0);
    check("t5_inst", if_inst, 32'h0);
    rst = 1'b1; ack_en = 1'b1;
    for (int i = 0; i < 10 && !bus.req; i++) tick();
    check("t5_refetch_addr", bus.addr, 32'h0);
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    check("t5_refetch_pc", if_pc, 32'h0);
    check("t5_refetch_inst", if_inst, 32'hA5A5_0000);
    repeat (3) tick();

    mdl_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
